// File: rtl/frv_intc_pkg.sv
// Shared constants for the frv_intc interrupt controller: MMIO register
// offsets, fixed trap causes and trap-request FSM state encodings.
package frv_intc_pkg;

    localparam logic [11:0] INTC_PENDING = 12'h000;
    localparam logic [11:0] INTC_ENABLE  = 12'h004;
    localparam logic [11:0] INTC_MODE    = 12'h008;
    localparam logic [11:0] INTC_CLAIM   = 12'h00C;

    localparam logic [5:0] INTC_CAUSE_NMI = 6'd0;
    localparam logic [5:0] INTC_CAUSE_SW  = 6'd3;
    localparam logic [5:0] INTC_CAUSE_TI  = 6'd7;

    localparam logic [1:0] INTC_ST_IDLE = 2'd0;
    localparam logic [1:0] INTC_ST_REQ  = 2'd1;
    localparam logic [1:0] INTC_ST_HOLD = 2'd2;

endpackage

// File: rtl/frv_intc_line.sv
// One interrupt line: 2-flop synchroniser, rising-edge detect against the
// previous synchronised value, and a sticky pend flop used in edge mode.
module frv_intc_line (
    input  logic g_clk,
    input  logic g_reset,
    input  logic i_line,
    input  logic i_edge,
    input  logic i_clr,
    output logic o_pend
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_pend;
    logic w_rise;

    assign w_rise = r_s2 & ~r_prev;

    // A rising edge in the same cycle as a clear keeps the line pending.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_s1   <= i_line;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_pend <= i_edge & (w_rise | (r_pend & ~i_clr));
        end
    end

    assign o_pend = i_edge ? r_pend : r_s2;

endmodule

// File: rtl/frv_intc.sv
// frv_intc: machine-level interrupt controller with NUM_EXT external lines,
// an MMIO register window and a REQ/ack trap handshake toward the WB stage.
module frv_intc
    import frv_intc_pkg::*;
#(
    parameter int          NUM_EXT        = 8,
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000,
    parameter logic [5:0]  CAUSE_EXT_BASE = 6'd16
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic [NUM_EXT-1:0] int_ext,
    input  logic               int_nmi,
    input  logic               int_software,
    input  logic               ti_pending,
    input  logic               mstatus_mie,
    input  logic               mie_meie,
    input  logic               mie_mtie,
    input  logic               mie_msie,
    output logic               mip_meip,
    output logic               mip_mtip,
    output logic               mip_msip,
    output logic               int_trap_req,
    output logic [5:0]         int_trap_cause,
    input  logic               int_trap_ack,
    input  logic               mmio_en,
    input  logic               mmio_wen,
    input  logic [31:0]        mmio_addr,
    input  logic [31:0]        mmio_wdata,
    output logic [31:0]        mmio_rdata,
    output logic               mmio_error
);

    logic [NUM_EXT-1:0] r_enable;
    logic [NUM_EXT-1:0] r_mode;
    logic [1:0]         r_state;
    logic [5:0]         r_cause;
    logic               r_src_nmi;
    logic               r_src_ext;
    logic [4:0]         r_src_idx;
    logic               r_meip;
    logic               r_mtip;
    logic               r_msip;

    logic [NUM_EXT-1:0] w_pend;
    logic [NUM_EXT-1:0] w_ready;
    logic [NUM_EXT-1:0] w_clr;
    logic               w_nmi_pend;
    logic               w_nmi_clr;
    logic [31:0]        w_off;
    logic               w_hit;
    logic               w_is_pend;
    logic               w_is_en;
    logic               w_is_mode;
    logic               w_is_claim;
    logic               w_err;
    logic               w_rd_ok;
    logic               w_wr_ok;
    logic               w_claim_vld;
    logic [4:0]         w_claim_idx;
    logic               w_claim_take;
    logic               w_ack_take;
    logic               w_src_vld;
    logic [5:0]         w_cause;
    logic               w_src_nmi;
    logic               w_src_ext;
    logic               w_unused_wdata;

    assign w_unused_wdata = ^mmio_wdata;

    assign w_hit      = mmio_en && ((mmio_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
    assign w_off      = mmio_addr & ~MMIO_BASE_MASK;
    assign w_is_pend  = (w_off == 32'(INTC_PENDING));
    assign w_is_en    = (w_off == 32'(INTC_ENABLE));
    assign w_is_mode  = (w_off == 32'(INTC_MODE));
    assign w_is_claim = (w_off == 32'(INTC_CLAIM));
    assign w_err      = w_hit && ((mmio_addr[1:0] != 2'b00)
                                  || !(w_is_pend || w_is_en || w_is_mode || w_is_claim)
                                  || (mmio_wen && w_is_claim));
    assign w_rd_ok    = w_hit && !w_err && !mmio_wen;
    assign w_wr_ok    = w_hit && !w_err && mmio_wen;
    assign mmio_error = w_err;

    assign w_ready = w_pend & r_enable;

    // Lowest-index ready line; shared by CLAIM and trap arbitration.
    always_comb begin
        w_claim_vld = 1'b0;
        w_claim_idx = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_claim_vld = 1'b1;
                w_claim_idx = 5'(i);
            end
        end
    end

    assign w_claim_take = w_rd_ok && w_is_claim && w_claim_vld;
    assign w_ack_take   = int_trap_ack && (r_state == INTC_ST_REQ);
    assign w_nmi_clr    = w_ack_take && r_src_nmi;

    for (genvar i = 0; i < NUM_EXT; i++) begin : g_line
        assign w_clr[i] = (w_wr_ok && w_is_pend && mmio_wdata[i])
                       || (w_wr_ok && w_is_mode && (mmio_wdata[i] != r_mode[i]))
                       || (w_claim_take && (w_claim_idx == 5'(i)))
                       || (w_ack_take && r_src_ext && (r_src_idx == 5'(i)));
        frv_intc_line u_line (
            .g_clk   (g_clk),
            .g_reset (g_reset),
            .i_line  (int_ext[i]),
            .i_edge  (r_mode[i]),
            .i_clr   (w_clr[i]),
            .o_pend  (w_pend[i])
        );
    end

    frv_intc_line u_nmi (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .i_line  (int_nmi),
        .i_edge  (1'b1),
        .i_clr   (w_nmi_clr),
        .o_pend  (w_nmi_pend)
    );

    always_comb begin
        mmio_rdata = '0;
        if (w_rd_ok) begin
            if (w_is_pend)     mmio_rdata[NUM_EXT-1:0] = w_pend;
            else if (w_is_en)  mmio_rdata[NUM_EXT-1:0] = r_enable;
            else if (w_is_mode) mmio_rdata[NUM_EXT-1:0] = r_mode;
            else               mmio_rdata = {w_claim_vld, 26'b0, w_claim_idx};
        end
    end

    // Fixed priority: NMI (ungated) > external > software > timer.
    always_comb begin
        w_src_vld = 1'b0;
        w_cause   = '0;
        w_src_nmi = 1'b0;
        w_src_ext = 1'b0;
        if (w_nmi_pend) begin
            w_src_vld = 1'b1;
            w_cause   = INTC_CAUSE_NMI;
            w_src_nmi = 1'b1;
        end else if (mstatus_mie && mie_meie && w_claim_vld) begin
            w_src_vld = 1'b1;
            w_cause   = CAUSE_EXT_BASE + {1'b0, w_claim_idx};
            w_src_ext = 1'b1;
        end else if (mstatus_mie && mie_msie && int_software) begin
            w_src_vld = 1'b1;
            w_cause   = INTC_CAUSE_SW;
        end else if (mstatus_mie && mie_mtie && ti_pending) begin
            w_src_vld = 1'b1;
            w_cause   = INTC_CAUSE_TI;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_state   <= INTC_ST_IDLE;
            r_cause   <= '0;
            r_src_nmi <= 1'b0;
            r_src_ext <= 1'b0;
            r_src_idx <= '0;
            r_meip    <= 1'b0;
            r_mtip    <= 1'b0;
            r_msip    <= 1'b0;
        end else begin
            r_meip <= |w_ready;
            r_mtip <= ti_pending;
            r_msip <= int_software;
            if (w_wr_ok && w_is_en)   r_enable <= mmio_wdata[NUM_EXT-1:0];
            if (w_wr_ok && w_is_mode) r_mode   <= mmio_wdata[NUM_EXT-1:0];
            case (r_state)
                INTC_ST_IDLE: if (w_src_vld) begin
                    r_state   <= INTC_ST_REQ;
                    r_cause   <= w_cause;
                    r_src_nmi <= w_src_nmi;
                    r_src_ext <= w_src_ext;
                    r_src_idx <= w_claim_idx;
                end
                INTC_ST_REQ:  if (int_trap_ack) r_state <= INTC_ST_HOLD;
                INTC_ST_HOLD: r_state <= INTC_ST_IDLE;
                default:      r_state <= INTC_ST_IDLE;
            endcase
        end
    end

    assign int_trap_req   = (r_state == INTC_ST_REQ);
    assign int_trap_cause = r_cause;
    assign mip_meip       = r_meip;
    assign mip_mtip       = r_mtip;
    assign mip_msip       = r_msip;

endmodule

// File: tb/tb_frv_intc.sv
// Bench for frv_intc: directed scenarios plus randomized line/enable/mode
// trials; expected traps and MMIO responses are queued and checked by monitors.
module tb_frv_intc;
    import frv_intc_pkg::*;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] A_PEND  = BASE + 32'(INTC_PENDING);
    localparam logic [31:0] A_EN    = BASE + 32'(INTC_ENABLE);
    localparam logic [31:0] A_MODE  = BASE + 32'(INTC_MODE);
    localparam logic [31:0] A_CLAIM = BASE + 32'(INTC_CLAIM);

    logic         g_clk = 1'b0;
    logic         g_reset;
    logic [N-1:0] int_ext;
    logic         int_nmi, int_software, ti_pending;
    logic         mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic         mip_meip, mip_mtip, mip_msip;
    logic         int_trap_req;
    logic [5:0]   int_trap_cause;
    logic         int_trap_ack;
    logic         mmio_en, mmio_wen;
    logic [31:0]  mmio_addr, mmio_wdata, mmio_rdata;
    logic         mmio_error;

    frv_intc #(.NUM_EXT(N)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .int_ext(int_ext), .int_nmi(int_nmi),
        .int_software(int_software), .ti_pending(ti_pending), .mstatus_mie(mstatus_mie),
        .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
        .mip_meip(mip_meip), .mip_mtip(mip_mtip), .mip_msip(mip_msip),
        .int_trap_req(int_trap_req), .int_trap_cause(int_trap_cause), .int_trap_ack(int_trap_ack),
        .mmio_en(mmio_en), .mmio_wen(mmio_wen), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata), .mmio_error(mmio_error)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } mexp_t;

    logic [5:0] cause_q[$];
    mexp_t      mq[$];
    int         ack_delay = 0;
    logic       no_ack = 1'b0;
    int         req_seen_cyc = 0;
    int         ack_cyc = 0;
    int         gap_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    task automatic mmio_rd(input logic [31:0] a, input logic [31:0] exp, input logic err);
        mq.push_back('{wr: 1'b0, data: exp, err: err});
        mmio_en = 1'b1; mmio_wen = 1'b0; mmio_addr = a;
        ticks(1);
        mmio_en = 1'b0;
    endtask

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d, input logic err);
        mq.push_back('{wr: 1'b1, data: 32'h0, err: err});
        mmio_en = 1'b1; mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = d;
        ticks(1);
        mmio_en = 1'b0; mmio_wen = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (cause_q.size() > n && k < 300) begin
            ticks(1);
            k++;
        end
        if (cause_q.size() > n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_trap: %0d traps outstanding, expected at most %0d", cause_q.size(), n);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Trap monitor: compares the cause on each new request, watches it stay
    // stable while held, then acknowledges after ack_delay cycles.
    initial begin : trap_monitor
        logic [5:0] held;
        int_trap_ack = 1'b0;
        forever begin
            @(negedge g_clk);
            if (int_trap_req === 1'b1) begin
                gap_cyc      = cyc - ack_cyc;
                req_seen_cyc = cyc;
                held         = int_trap_cause;
                if (cause_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL trap_unexpected: got cause %0d, expected no request", held);
                end else begin
                    chk("trap_cause", 32'(held), 32'(cause_q.pop_front()));
                end
                for (int k = 0; k < ack_delay && int_trap_req; k++) begin
                    @(negedge g_clk);
                    if (int_trap_req) begin
                        chk("req_held", 32'(int_trap_req), 32'd1);
                        chk("cause_stable", 32'(int_trap_cause), 32'(held));
                    end
                end
                if (no_ack) begin
                    for (int k = 0; k < 50 && int_trap_req; k++) @(negedge g_clk);
                    chk("req_dropped", 32'(int_trap_req), 32'd0);
                end else if (int_trap_req) begin
                    int_trap_ack = 1'b1;
                    ack_cyc      = cyc;
                    @(negedge g_clk);
                    int_trap_ack = 1'b0;
                    chk("hold_req_low", 32'(int_trap_req), 32'd0);
                end
            end
        end
    end

    initial begin : mmio_monitor
        mexp_t e;
        forever begin
            @(negedge g_clk);
            if (mmio_en === 1'b1) begin
                if (mq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mmio_unexpected: got access at %0h, expected none", mmio_addr);
                end else begin
                    e = mq.pop_front();
                    chk("mmio_error", 32'(mmio_error), 32'(e.err));
                    if (!e.wr) chk("mmio_rdata", mmio_rdata, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [N-1:0] m, e, s, pend;
        logic [31:0]  r32, exp;
        int           idx, raise_cyc;

        g_reset = 1'b1; int_ext = '0; int_nmi = 1'b0; int_software = 1'b0; ti_pending = 1'b0;
        mstatus_mie = 1'b0; mie_meie = 1'b0; mie_mtie = 1'b0; mie_msie = 1'b0;
        mmio_en = 1'b0; mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = '0;
        repeat (3) @(posedge g_clk);
        #1;
        g_reset = 1'b0;

        // Reset state
        chk("rst_req", 32'(int_trap_req), 32'd0);
        chk("rst_cause", 32'(int_trap_cause), 32'd0);
        chk("rst_mip", 32'({mip_meip, mip_mtip, mip_msip}), 32'd0);
        chk("rst_rdata", mmio_rdata, 32'd0);
        chk("rst_error", 32'(mmio_error), 32'd0);
        mmio_rd(A_EN, 32'h0, 1'b0);
        mmio_rd(A_CLAIM, 32'h0, 1'b0);

        // Level line 5: latency and re-request after HOLD
        ack_delay = 0;
        mmio_wr(A_EN, 32'h24, 1'b0);
        mie_meie = 1'b1; mstatus_mie = 1'b1;
        cause_q.push_back(6'd21);
        raise_cyc = cyc;
        int_ext[5] = 1'b1;
        wait_q(0);
        chk("req_latency", 32'(req_seen_cyc - raise_cyc), 32'd3);
        chk("mip_meip", 32'(mip_meip), 32'd1);
        cause_q.push_back(6'd21);
        wait_q(0);
        mstatus_mie = 1'b0;
        chk("hold_gap", 32'(gap_cyc), 32'd3);
        int_ext = '0;
        ticks(8);

        // Edge line 2: PENDING, CLAIM, second CLAIM
        mmio_wr(A_MODE, 32'h4, 1'b0);
        mmio_wr(A_EN, 32'h4, 1'b0);
        int_ext[2] = 1'b1;
        ticks(1);
        int_ext[2] = 1'b0;
        ticks(4);
        mmio_rd(A_PEND, 32'h4, 1'b0);
        mmio_rd(A_CLAIM, 32'h8000_0002, 1'b0);
        mmio_rd(A_CLAIM, 32'h0, 1'b0);

        // Priority: NMI (with mstatus_mie=0), ext 1, software, timer
        ack_delay = 1;
        mmio_wr(A_MODE, 32'h2, 1'b0);
        mmio_wr(A_EN, 32'h2, 1'b0);
        mie_msie = 1'b1; mie_mtie = 1'b1;
        cause_q.push_back(6'd0); cause_q.push_back(6'd17);
        cause_q.push_back(6'd3); cause_q.push_back(6'd7);
        int_nmi = 1'b1; int_ext[1] = 1'b1; int_software = 1'b1;
        wait_q(3);
        chk("mip_msip", 32'(mip_msip), 32'd1);
        chk("mip_meip_edge", 32'(mip_meip), 32'd1);
        int_nmi = 1'b0; int_ext = '0; ti_pending = 1'b1;
        mstatus_mie = 1'b1;
        wait_q(1);
        int_software = 1'b0;
        chk("mip_mtip", 32'(mip_mtip), 32'd1);
        wait_q(0);
        ti_pending = 1'b0;
        ticks(8);
        mstatus_mie = 1'b0;

        // Stability of a held request, then reset mid-request
        ack_delay = 6;
        mmio_wr(A_MODE, 32'h0, 1'b0);
        mstatus_mie = 1'b1;
        cause_q.push_back(6'd17);
        int_ext[1] = 1'b1;
        wait_q(0);
        int_ext[1] = 1'b0;
        ticks(14);
        no_ack = 1'b1;
        cause_q.push_back(6'd17);
        int_ext[1] = 1'b1;
        wait_q(0);
        ticks(1);
        g_reset = 1'b1;
        ticks(1);
        chk("req_after_reset", 32'(int_trap_req), 32'd0);
        g_reset = 1'b0;
        no_ack = 1'b0;
        int_ext = '0;
        mstatus_mie = 1'b0;
        ticks(6);

        // MMIO errors and a miss
        mmio_wr(A_CLAIM, 32'h1, 1'b1);
        mmio_rd(BASE + 32'h10, 32'h0, 1'b1);
        mmio_rd(BASE + 32'h02, 32'h0, 1'b1);
        mmio_rd(32'h0000_3004, 32'h0, 1'b0);

        // Randomized trials against a set/claim/ack model
        mie_meie = 1'b1; mie_msie = 1'b0; mie_mtie = 1'b0;
        for (int t = 0; t < 30; t++) begin
            ack_delay = $urandom_range(0, 3);
            r32 = $urandom;
            m = r32[N-1:0];
            s = N'($urandom);
            r32 = $urandom;
            e = r32[N-1:0];
            mmio_wr(A_MODE, {$urandom_range(0, 255), 16'h0, 8'(m)}, 1'b0);
            mmio_wr(A_EN, r32, 1'b0);
            mmio_rd(A_EN, 32'(e), 1'b0);
            int_ext = s;
            ticks(1);
            int_ext = s & ~m;
            ticks(4);
            pend = s;
            mmio_rd(A_PEND, 32'(pend), 1'b0);
            for (int c = 0; c < 3; c++) begin
                idx = lowest(pend & e);
                if (idx < 0) exp = 32'h0;
                else begin
                    exp = 32'h8000_0000 | 32'(idx);
                    if (m[idx]) pend[idx] = 1'b0;
                end
                mmio_rd(A_CLAIM, exp, 1'b0);
            end
            int_ext = '0;
            ticks(4);
            pend = pend & m;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && e[i]) begin
                    cause_q.push_back(6'd16 + 6'(i));
                    pend[i] = 1'b0;
                end
            end
            mstatus_mie = 1'b1;
            wait_q(0);
            ticks(8);
            mstatus_mie = 1'b0;
            ticks(2);
            mmio_rd(A_PEND, 32'(pend), 1'b0);
            mmio_wr(A_PEND, 32'hFFFF_FFFF, 1'b0);
            mmio_rd(A_PEND, 32'h0, 1'b0);
        end

        ticks(10);
        chk("traps_drained", 32'(cause_q.size()), 32'd0);
        chk("mmio_drained", 32'(mq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
